// File: rtl/pe_mac_multilane.sv
// ============================================================================
// Module   : pe_mac_multilane
// Purpose  : Multi-lane signed MAC PE; reduces LANES products per beat and
//            accumulates KERNEL_SIZE beats (plus optional psum) per window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mac_multilane #(
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 4,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(LANES*KERNEL_SIZE) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 psum_en,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]          ifmap_data_M2P,
  input  logic [LANES*DATA_WIDTH-1:0]          fltr_data_M2P,
  input  logic                                 psum_valid,
  output logic                                 psum_ready,
  input  logic [ACC_WIDTH-1:0]                 psum_data_M2P,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_WIDTH-1:0]                 psum_data_P2M,
  output logic [$clog2(KERNEL_SIZE+1)-1:0]     beat_cnt
);

  localparam int CNT_W  = $clog2(KERNEL_SIZE+1);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int EXT_W  = ACC_WIDTH - PROD_W;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_PSUM = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  psum_en_q, psum_en_d;

  logic [PROD_W-1:0]     w_prod [LANES];
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_first;
  logic                  w_last;
  logic                  w_go_psum;

  // Operands are pre-extended so the product is computed exactly at PROD_W.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_a, w_b;
    logic [PROD_W-1:0]     w_a_ext, w_b_ext;
    assign w_a       = ifmap_data_M2P[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_b       = fltr_data_M2P[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_a_ext   = {{DATA_WIDTH{w_a[DATA_WIDTH-1]}}, w_a};
    assign w_b_ext   = {{DATA_WIDTH{w_b[DATA_WIDTH-1]}}, w_b};
    assign w_prod[i] = w_a_ext * w_b_ext;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{EXT_W{w_prod[i][PROD_W-1]}}, w_prod[i]};
    end
  end

  assign w_first   = (cnt_q == '0);
  assign w_last    = (cnt_q == CNT_W'(KERNEL_SIZE-1));
  // A single-beat window has no earlier beat to have latched psum_en.
  assign w_go_psum = w_first ? psum_en : psum_en_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    psum_en_d  = psum_en_q;
    in_ready   = (state_q == ST_ACC) && !clear && !rst;
    psum_ready = (state_q == ST_PSUM);
    out_valid  = (state_q == ST_OUT);

    if (clear) begin
      state_d   = ST_ACC;
      acc_d     = '0;
      cnt_d     = '0;
      psum_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid && in_ready) begin
            acc_d = w_first ? w_sum : acc_q + w_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (w_first) psum_en_d = psum_en;
            if (w_last)  state_d   = w_go_psum ? ST_PSUM : ST_OUT;
          end
        end
        ST_PSUM: begin
          if (psum_valid) begin
            acc_d   = acc_q + psum_data_M2P;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            cnt_d   = '0;
            state_d = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      psum_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      psum_en_q <= psum_en_d;
    end
  end

  assign psum_data_P2M = out_valid ? acc_q : '0;
  assign beat_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_mac_multilane.sv
// ============================================================================
// Module   : tb_pe_mac_multilane
// Purpose  : Directed self-checking bench for pe_mac_multilane at defaults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_mac_multilane;

  localparam int DW   = 16;
  localparam int LN   = 4;
  localparam int KS   = 9;
  localparam int AW   = 2*DW + $clog2(LN*KS) + 1;
  localparam int CW   = $clog2(KS+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              psum_en;
  logic              in_valid;
  logic              in_ready;
  logic [LN*DW-1:0]  ifmap;
  logic [LN*DW-1:0]  fltr;
  logic              psum_valid;
  logic              psum_ready;
  logic [AW-1:0]     psum_in;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     psum_out;
  logic [CW-1:0]     beat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mac_multilane #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .KERNEL_SIZE(KS),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .psum_en       (psum_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ifmap_data_M2P(ifmap),
    .fltr_data_M2P (fltr),
    .psum_valid    (psum_valid),
    .psum_ready    (psum_ready),
    .psum_data_M2P (psum_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .psum_data_P2M (psum_out),
    .beat_cnt      (beat_cnt)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives n beats of identical lane operands from a negedge; optional one-cycle gaps.
  task automatic feed(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                      input int n, input bit gaps);
    ifmap = {LN{a}};
    fltr  = {LN{b}};
    for (int k = 1; k <= n; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("beat_cnt", beat_cnt, k);
      if (gaps && k < n) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("beat_cnt_gap", beat_cnt, k);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    psum_en    = 1'b0;
    in_valid   = 1'b0;
    ifmap      = '0;
    fltr       = '0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",   in_ready, 0);
    chk("rst_psum_ready", psum_ready, 0);
    chk("rst_out_valid",  out_valid, 0);
    chk("rst_data",       psum_out, 0);
    chk("rst_beat_cnt",   beat_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Basic window, no psum
    feed(16'sd1, 16'sd2, KS, 1'b0);
    chk("w1_out_valid", out_valid, 1);
    chk("w1_data", $signed(psum_out), 72);
    chk("w1_in_ready", in_ready, 0);
    @(negedge clk);
    chk("w1_pulse_end", out_valid, 0);
    chk("w1_cnt_reset", beat_cnt, 0);

    // Window with psum presented 4 cycles late
    psum_en = 1'b1;
    feed(16'sd1, 16'sd2, KS, 1'b0);
    psum_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w2_psum_ready_wait", psum_ready, 1);
      chk("w2_no_out_wait", out_valid, 0);
      @(negedge clk);
    end
    chk("w2_psum_ready", psum_ready, 1);
    psum_valid = 1'b1;
    psum_in    = AW'(3);
    @(negedge clk);
    psum_valid = 1'b0;
    chk("w2_psum_ready_drop", psum_ready, 0);
    chk("w2_out_valid", out_valid, 1);
    chk("w2_data", $signed(psum_out), 75);
    @(negedge clk);
    chk("w2_pulse_end", out_valid, 0);

    // Negative operands with gaps: 9 * 4 * (-15)
    feed(-16'sd3, 16'sd5, KS, 1'b1);
    chk("w3_out_valid", out_valid, 1);
    chk("w3_data", $signed(psum_out), -540);
    @(negedge clk);
    chk("w3_pulse_end", out_valid, 0);

    // Extreme operands with downstream stall
    out_ready = 1'b0;
    feed(-16'sd32768, -16'sd32768, KS, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("w4_out_valid_hold", out_valid, 1);
      chk("w4_data_hold", $signed(psum_out), 64'sd38654705664);
      chk("w4_in_ready_hold", in_ready, 0);
      chk("w4_cnt_hold", beat_cnt, KS);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("w4_release", out_valid, 0);
    chk("w4_cnt_reset", beat_cnt, 0);

    // Abort a window with clear, then run a clean one
    feed(16'sd1, 16'sd2, 5, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt", beat_cnt, 0);
    chk("clr_out_valid", out_valid, 0);
    feed(16'sd1, 16'sd2, KS, 1'b0);
    chk("w5_out_valid", out_valid, 1);
    chk("w5_data", $signed(psum_out), 72);
    @(negedge clk);

    // Asynchronous reset mid-window
    feed(16'sd1, 16'sd2, 4, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_cnt", beat_cnt, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_data", psum_out, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    feed(16'sd1, 16'sd2, KS, 1'b0);
    chk("w6_out_valid", out_valid, 1);
    chk("w6_data", $signed(psum_out), 72);
    @(negedge clk);
    chk("w6_pulse_end", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
